fir_sample_feeder: RTL and testbench
====================================

// Module: fir_sample_feeder
// PURPOSE
//  Transmit side of the FIR sample stream: buffers a programmed burst of signed samples, then plays it
//  into a filter's x input at a fixed sample rate. Appends zero samples so the filter's taps drain.
//  Sits upstream of fir_filter; replaces hand-driven stimulus in system-level and on-chip test paths.
// PARAMETERS
//  DATA_W     8   sample width, signed two's complement
//  DEPTH      16  sample buffer entries (power of 2, >=2)
//  FLUSH_LEN  4   zero samples appended after each burst (>=0; set to filter tap count)
//  RATE_DIV   1   clock cycles per output sample (>=1)
// PORTS
//  clk         in   1                 rising-edge clock
//  rst         in   1                 synchronous, active-high reset
//  load_valid  in   1                 sample write request
//  load_data   in   DATA_W            signed sample to append to buffer
//  load_ready  out  1                 buffer accepts write this cycle
//  clear       in   1                 empty buffer (count->0); acted on only in IDLE
//  start       in   1                 begin playback of buffered burst
//  x           out  DATA_W            signed sample to filter
//  x_valid     out  1                 one-cycle strobe: x carries a new sample
//  busy        out  1                 high in PLAY and FLUSH
//  done        out  1                 one-cycle pulse at end of burst+flush
//  count       out  $clog2(DEPTH)+1   samples held in buffer
// BEHAVIOUR
//  - Reset: state IDLE; x=0, x_valid=0, busy=0, done=0, count=0, load_ready=1; read index/divider=0.
//  - Load: write when load_valid&&load_ready; load_ready = (state==IDLE)&&(count<DEPTH). Full: load_ready=0,
//    data dropped (no overwrite). Buffer contents persist after playback: start replays same burst.
//  - clear in IDLE: count->0 next cycle; clear and load same cycle: clear wins, sample dropped.
//  - FSM IDLE->PLAY on start&&count!=0; start with count==0 ignored (no busy, no done).
//    PLAY: emits count samples, index 0..count-1. PLAY->FLUSH after last sample (skip FLUSH if FLUSH_LEN=0).
//    FLUSH: emits FLUSH_LEN zeros. ->IDLE with done=1 in the cycle after the final strobe.
//    start, load_valid, clear ignored while busy.
//  - Timing: start sampled at edge t -> first x_valid at edge t+1 (x=buf[0]); subsequent strobes every
//    RATE_DIV cycles. Total strobes = count+FLUSH_LEN. busy rises with first strobe, falls with done.
//  - x registered; holds its value between strobes; forced to 0 in IDLE.
//  - Divider counts 0..RATE_DIV-1, restarts at 0 on every IDLE->PLAY; strobe at divider==0.
//  - Signed values passed unmodified (8'h80 emitted as -128); no arithmetic on samples.
//  - rst mid-operation: immediate return to reset state, buffer count zeroed, no done pulse.
// CONFIGURATION
//  FIR_FEEDER_LOOP_EN defined: adds input port `loop` (1 bit). If loop=1 when the last PLAY sample is
//    strobed, index wraps to 0 and PLAY continues without flush/done; loop=0 at that point -> FLUSH normally.
//    Strobe spacing stays exactly RATE_DIV across the wrap.
//  Not defined: no loop port; behaves as loop=0 (single burst per start).
// STRUCTURE
//  - fir_pkg: SAMPLE_W constant, sample_t signed typedef, feeder_state_t enum {IDLE,PLAY,FLUSH}.
//  - Sub-module fir_sample_ram: DEPTH x DATA_W single-write, async/comb-read register array;
//    read index registered in parent so x is a flop output. Control FSM and divider stay in top.
// TESTING
//  1 RATE_DIV=1,FLUSH_LEN=4: load 1,2,3,4; start -> x_valid 8 consecutive cycles, x=1,2,3,4,0,0,0,0; done 1 cycle after last.
//  2 Load DEPTH+1 samples back-to-back -> load_ready low after 16th, count=16, 17th dropped, replay has 16.
//  3 start with count=0 -> busy/x_valid/done stay 0; then clear with count=3 -> count=0 next cycle.
//  4 RATE_DIV=3: load -128,127; start -> strobes at t+1,t+4,t+7..., x=8'h80 then 8'h7F, x held between.
//  5 rst asserted mid-PLAY (2nd sample) -> next cycle x=0,x_valid=0,busy=0,count=0, no done pulse.
//  6 FIR_FEEDER_LOOP_EN: load 5,6, loop=1 -> 5,6,5,6,... with uniform spacing; drop loop -> finishes pass, 4 zeros, done.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample type and feeder FSM state encoding
package fir_pkg;
    localparam int SAMPLE_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        FLUSH = 2'd2
    } feeder_state_t;
endpackage

// File: rtl/fir_sample_ram.sv
// rtl/fir_sample_ram.sv - single-write, combinational-read sample buffer
module fir_sample_ram
    import fir_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic        [AW-1:0]     waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic        [AW-1:0]     raddr,
    output logic signed [DATA_W-1:0] rdata
);
    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - buffers a sample burst and plays it, plus zero flush, into a FIR x input
// Optional FIR_FEEDER_LOOP_EN adds a loop input that repeats the burst without flushing.
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int DEPTH     = 16,
    parameter int FLUSH_LEN = 4,
    parameter int RATE_DIV  = 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    input  logic signed [DATA_W-1:0] load_data,
    output logic                     load_ready,
    input  logic                     clear,
    input  logic                     start,
`ifdef FIR_FEEDER_LOOP_EN
    input  logic                     loop,
`endif
    output logic signed [DATA_W-1:0] x,
    output logic                     x_valid,
    output logic                     busy,
    output logic                     done,
    output logic        [CW-1:0]     count
);
    localparam int DVW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int FW  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    feeder_state_t state, state_nxt;
    logic [DVW-1:0] div;
    logic [AW-1:0]  idx;
    logic [FW-1:0]  fcnt;
    logic           fin;
    logic           loop_en;
    logic           tick, last_play, last_flush, fin_set, wr_en;
    logic signed [DATA_W-1:0] rd_data;

`ifdef FIR_FEEDER_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    fir_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[AW-1:0]),
        .wdata (load_data),
        .raddr (idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start && count != '0) state_nxt = PLAY;
            PLAY: begin
                if (fin)
                    state_nxt = IDLE;
                else if (last_play && !loop_en && FLUSH_LEN > 0)
                    state_nxt = FLUSH;
            end
            FLUSH: if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // fin marks "final strobe issued"; the FSM leaves PLAY/FLUSH one cycle later with done.
    always_comb begin
        load_ready = (state == IDLE) && (count < CW'(DEPTH));
        wr_en      = load_valid && load_ready && !clear;
        tick       = (state != IDLE) && !fin && (div == '0);
        last_play  = tick && (state == PLAY) && (CW'(idx) == count - CW'(1));
        last_flush = tick && (state == FLUSH) && (int'(fcnt) == FLUSH_LEN - 1);
        fin_set    = (last_play && !loop_en && FLUSH_LEN == 0) || last_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= '0;
            idx     <= '0;
            fcnt    <= '0;
            fin     <= 1'b0;
            count   <= '0;
            x       <= '0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            x_valid <= tick;
            done    <= fin;
            if (state == IDLE) begin
                div  <= '0;
                idx  <= '0;
                fcnt <= '0;
                fin  <= 1'b0;
                busy <= 1'b0;
                x    <= '0;
                if (clear)      count <= '0;
                else if (wr_en) count <= count + CW'(1);
            end else begin
                // Divider free-runs through a loop wrap so strobe spacing stays uniform.
                div <= (int'(div) == RATE_DIV - 1) ? '0 : div + DVW'(1);
                if (tick && state == PLAY)  idx  <= last_play ? '0 : idx + AW'(1);
                if (tick && state == FLUSH) fcnt <= fcnt + FW'(1);
                if (fin_set)   fin <= 1'b1;
                else if (fin)  fin <= 1'b0;
                if (tick)      busy <= 1'b1;
                else if (fin)  busy <= 1'b0;
                if (fin)       x <= '0;
                else if (tick) x <= (state == PLAY) ? rd_data : '0;
            end
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - directed self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;
    logic clk = 1'b0;
    logic rst;
    logic lv, cl, st;
    logic signed [7:0] ld;
    logic lr, xv, bsy, dn;
    logic signed [7:0] x;
    logic [4:0] cnt;
    logic lv3, cl3, st3;
    logic signed [7:0] ld3;
    logic lr3, xv3, bsy3, dn3;
    logic signed [7:0] x3;
    logic [4:0] cnt3;
`ifdef FIR_FEEDER_LOOP_EN
    logic lp, lp3;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fir_sample_feeder #(.DATA_W(8), .DEPTH(16), .FLUSH_LEN(4), .RATE_DIV(1)) dut (
        .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(lr),
        .clear(cl), .start(st),
`ifdef FIR_FEEDER_LOOP_EN
        .loop(lp),
`endif
        .x(x), .x_valid(xv), .busy(bsy), .done(dn), .count(cnt)
    );

    fir_sample_feeder #(.DATA_W(8), .DEPTH(16), .FLUSH_LEN(4), .RATE_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .load_valid(lv3), .load_data(ld3), .load_ready(lr3),
        .clear(cl3), .start(st3),
`ifdef FIR_FEEDER_LOOP_EN
        .loop(lp3),
`endif
        .x(x3), .x_valid(xv3), .busy(bsy3), .done(dn3), .count(cnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic signed [7:0] v);
        lv = 1'b1; ld = v;
        step();
        lv = 1'b0;
    endtask

    task automatic load3(input logic signed [7:0] v);
        lv3 = 1'b1; ld3 = v;
        step();
        lv3 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lv = 0; cl = 0; st = 0; ld = 0;
        lv3 = 0; cl3 = 0; st3 = 0; ld3 = 0;
`ifdef FIR_FEEDER_LOOP_EN
        lp = 0; lp3 = 0;
`endif
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_x", x, 0);
        chk("rst_xv", xv, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_done", dn, 0);
        chk("rst_count", cnt, 0);
        chk("rst_ready", lr, 1);

        // 1: four samples, unit rate, four flush zeros
        load(1); load(2); load(3); load(4);
        chk("t1_count", cnt, 4);
        st = 1'b1; step(); st = 1'b0;
        chk("t1_pre_xv", xv, 0);
        chk("t1_pre_busy", bsy, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_xv", xv, 1);
            chk("t1_x", x, (k < 4) ? k + 1 : 0);
            chk("t1_busy", bsy, 1);
            chk("t1_done", dn, 0);
        end
        step();
        chk("t1_end_done", dn, 1);
        chk("t1_end_xv", xv, 0);
        chk("t1_end_busy", bsy, 0);
        chk("t1_end_x", x, 0);
        step();
        chk("t1_done_once", dn, 0);
        chk("t1_count_kept", cnt, 4);

        // 2: overfill; 17th sample dropped, replay shows 16
        cl = 1'b1; step(); cl = 1'b0;
        chk("t2_clear", cnt, 0);
        for (int i = 0; i < 17; i++) begin
            lv = 1'b1; ld = 8'(10 + i);
            #1 chk("t2_ready", lr, (i < 16) ? 1 : 0);
            step();
        end
        lv = 1'b0;
        chk("t2_count", cnt, 16);
        st = 1'b1; step(); st = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t2_xv", xv, 1);
            chk("t2_x", x, (k < 16) ? 10 + k : 0);
        end
        step();
        chk("t2_done", dn, 1);

        // 3: start on empty buffer, then clear beats a same-cycle load
        cl = 1'b1; step(); cl = 1'b0;
        st = 1'b1; step(); st = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_busy", bsy, 0);
            chk("t3_xv", xv, 0);
            chk("t3_done", dn, 0);
            step();
        end
        load(7); load(8); load(9);
        chk("t3_count3", cnt, 3);
        cl = 1'b1; lv = 1'b1; ld = 8'sd5; step(); cl = 1'b0; lv = 1'b0;
        chk("t3_clear_wins", cnt, 0);

        // 4: RATE_DIV=3 with extreme signed values
        load3(-128); load3(127);
        chk("t4_count", cnt3, 2);
        st3 = 1'b1; step(); st3 = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            step();
            chk("t4_xv", xv3, (c % 3 == 1 && c <= 16) ? 1 : 0);
            chk("t4_x", x3, (c <= 3) ? -128 : (c <= 6) ? 127 : 0);
            chk("t4_busy", bsy3, (c <= 16) ? 1 : 0);
            chk("t4_done", dn3, (c == 17) ? 1 : 0);
        end

        // 5: reset during the second PLAY sample
        load(1); load(2); load(3); load(4);
        st = 1'b1; step(); st = 1'b0;
        step();
        chk("t5_first", x, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_x", x, 0);
        chk("t5_xv", xv, 0);
        chk("t5_busy", bsy, 0);
        chk("t5_count", cnt, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t5_no_done", dn, 0);
            step();
        end

`ifdef FIR_FEEDER_LOOP_EN
        // 6: looped playback, then a final pass with flush
        load(5); load(6);
        lp = 1'b1;
        st = 1'b1; step(); st = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_loop_xv", xv, 1);
            chk("t6_loop_x", x, (k % 2 == 1) ? 6 : 5);
        end
        lp = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t6_tail_xv", xv, 1);
            chk("t6_tail_x", x, (k == 0) ? 5 : (k == 1) ? 6 : 0);
            chk("t6_tail_done", dn, 0);
        end
        step();
        chk("t6_done", dn, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
